// File: rtl/multiplicador.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier, one iteration per clock,
// with a start/busy/done handshake; the 2*WIDTH-bit product lands in hi/lo.
module multiplicador #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multOp,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   m_sext_s;
  logic [WIDTH:0]   sum_s;

  // Accumulator is one bit wider than M so A +/- M cannot overflow, even for M = -2^(WIDTH-1).
  assign m_sext_s = {m_q[WIDTH-1], m_q};

  // State register and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and one Booth step (add/sub, then arithmetic shift of {A,Q,Q_1}).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum_s   = a_q;

    case (state_q)
      IDLE: begin
        if (multOp) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          q1_d    = 1'b0;
          a_d     = '0;
          count_d = CW'(WIDTH);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        case ({q_q[0], q1_q})
          2'b01:   sum_s = a_q + m_sext_s;
          2'b10:   sum_s = a_q - m_sext_s;
          default: sum_s = a_q;
        endcase
        a_d     = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_d     = {sum_s[0], q_q[WIDTH-1:1]};
        q1_d    = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          hi_d    = a_d[WIDTH-1:0];
          lo_d    = q_d;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplicador.sv
// Directed-vector bench for multiplicador: the driver pushes expected products into a
// queue, and a negedge monitor pops and compares on every done pulse.
module tb_multiplicador;

  logic        clk;
  logic        reset;
  logic        multOp;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'd0;
  logic        done_prev = 1'b0;

  multiplicador #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .multOp       (multOp),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: result on each done, no back-to-back done, hi/lo hold while busy.
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        checks++;
        if (done_prev) begin
          errors++;
          $display("FAIL done_twice: done high on two consecutive cycles");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got hi=%h lo=%h with nothing expected", hi, lo);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({hi, lo} !== e) begin
            errors++;
            $display("FAIL product: got %h_%h expected %h_%h", hi, lo, e[63:32], e[31:0]);
          end
          last_res = e;
        end
      end else if (busy) begin
        checks++;
        if ({hi, lo} !== last_res) begin
          errors++;
          $display("FAIL hold: hi/lo changed while busy, got %h_%h expected %h_%h",
                   hi, lo, last_res[63:32], last_res[31:0]);
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic start_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] e,
                          output int busy_cnt);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    multOp       = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    multOp   = 1'b0;
    busy_cnt = busy ? 1 : 0;
  endtask

  // Returns edges-after-start until done is seen (-1 on timeout), accumulating busy cycles.
  task automatic wait_done(inout int busy_cnt, output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      busy_cnt += busy ? 1 : 0;
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL timeout: done not seen within 100 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] e);
    int bc;
    int lat;
    start_op(m, q, e, bc);
    wait_done(bc, lat);
    check({name, "_latency"}, 64'(lat), 64'd32);
    check({name, "_busy_cycles"}, 64'(bc), 64'd32);
  endtask

  initial begin
    int bc;
    int lat;
    int ndone;
    int t[3];

    reset        = 1'b0;
    multOp       = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b1;

    run_op("3x5",    32'd3,          32'd5,          64'h00000000_0000000F);
    run_op("m3x5",   32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1);
    run_op("m1xm1",  32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001);
    run_op("0xk",    32'd0,          32'h12345678,   64'h00000000_00000000);
    run_op("minmin", 32'h80000000,   32'h80000000,   64'h40000000_00000000);
    run_op("maxmax", 32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF_00000001);
    run_op("minmax", 32'h80000000,   32'h7FFFFFFF,   64'hC0000000_80000000);

    // Start request and operand changes mid-run must not disturb 6x7.
    start_op(32'd6, 32'd7, 64'd42, bc);
    repeat (9) @(negedge clk);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    multOp       = 1'b1;
    @(negedge clk);
    multOp       = 1'b0;
    multiplicand = 32'hDEADBEEF;
    multiplier   = 32'h13572468;
    wait_done(bc, lat);
    check("ignore_start_latency", 64'(lat + 10), 64'd32);
    repeat (5) @(negedge clk);
    check("ignore_start_idle", 64'({busy, done}), 64'd0);

    // Asynchronous reset between edges in the middle of an operation.
    start_op(32'd5, 32'd5, 64'd25, bc);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_busy_done", 64'({busy, done}), 64'd0);
    exp_q.delete();
    last_res = 64'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op("after_reset_2x2", 32'd2, 32'd2, 64'd4);

    // Back-to-back: multOp held high restarts every WIDTH+2 cycles.
    @(negedge clk);
    multiplicand = 32'd4;
    multiplier   = 32'd4;
    multOp       = 1'b1;
    repeat (3) exp_q.push_back(64'd16);
    ndone = 0;
    for (int i = 1; i <= 200 && ndone < 3; i++) begin
      @(negedge clk);
      if (done) begin
        t[ndone] = i;
        ndone++;
        if (ndone == 3) multOp = 1'b0;
      end
    end
    multOp = 1'b0;
    check("b2b_count", 64'(ndone), 64'd3);
    if (ndone == 3) begin
      check("b2b_first", 64'(t[0]), 64'd33);
      check("b2b_period1", 64'(t[1] - t[0]), 64'd34);
      check("b2b_period2", 64'(t[2] - t[1]), 64'd34);
    end
    repeat (40) @(negedge clk);
    check("b2b_stopped", 64'(busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
